id_stage_param: RTL

Parametrised instruction-decode stage for the 16-bit-ISA pipeline. It contains:
- the architectural register file, with write-through bypass;
- immediate extension;
- an N-source operand forwarding mux;
- branch compare;
- the ID/EX pipeline register, with valid, stall and flush control.

It sits between the IF/ID register and the EX stage. It generalises the fixed 16-bit, 3-source decode to DATA_W-bit datapaths, NUM_FWD forwarding sources, and bubble handling.

---
 rtl/id_stage_param.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_stage_param.sv
// Decode stage: register file with write-through bypass, immediate extension, operand forwarding, branch compare.
// One cycle to the ID/EX register; stall holds the entry, flush turns it into a bubble.
module id_stage_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_FWD  = 3,
  parameter int LINK_REG = 7,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [15:0]               instruction,
  input  logic [DATA_W-1:0]         npc,
  input  logic [4:0]                ctrl,
  input  logic [SEL_W-1:0]          fwd_sel_a,
  input  logic [SEL_W-1:0]          fwd_sel_b,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      wb_en,
  input  logic [2:0]                wb_rd,
  input  logic [DATA_W-1:0]         wb_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         a,
  output logic [DATA_W-1:0]         b,
  output logic [2:0]                rd_out,
  output logic [DATA_W-1:0]         imm_out,
  output logic [DATA_W-1:0]         pc_out,
  output logic [DATA_W-1:0]         i_target,
  output logic [DATA_W-1:0]         j_target,
  output logic [DATA_W-1:0]         ret_addr,
  output logic                      gt,
  output logic                      lt,
  output logic                      eq
);

  logic [2:0]  rd, rs1, rs2, rs_a, rs_b, rd_next, link_addr;
  logic [7:0]  imm8;
  logic [11:0] jimm;
  logic        src1_zero, src2_rs2, rd_link, ext_signed, ext_high;
  logic        unused_ins;

  assign rd   = instruction[11:9];
  assign rs1  = instruction[8:6];
  assign rs2  = instruction[5:3];
  assign imm8 = instruction[7:0];
  assign jimm = instruction[11:0];
  assign unused_ins = ^instruction[15:12];
  assign {src1_zero, src2_rs2, rd_link, ext_signed, ext_high} = ctrl;

  assign rs_a      = src1_zero ? 3'd0 : rs1;
  assign rs_b      = src2_rs2 ? rs2 : rd;
  assign link_addr = 3'(LINK_REG);
  assign rd_next   = rd_link ? link_addr : rd;

  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] rf_a, rf_b, rf_link;

  // Same-cycle writeback is visible to all reads, so WB->ID needs no stall.
  always_comb begin
    rf_a    = '0;
    rf_b    = '0;
    rf_link = '0;
    if (rs_a != 3'd0)
      rf_a = (wb_en && wb_rd == rs_a) ? wb_data : regs[rs_a];
    if (rs_b != 3'd0)
      rf_b = (wb_en && wb_rd == rs_b) ? wb_data : regs[rs_b];
    if (link_addr != 3'd0)
      rf_link = (wb_en && wb_rd == link_addr) ? wb_data : regs[link_addr];
  end

  assign ret_addr = rf_link;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 3'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Selects beyond NUM_FWD fall back to the register file.
  logic [DATA_W-1:0] op_a, op_b;
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (fwd_sel_a == SEL_W'(k)) op_a = fwd_data[(k-1)*DATA_W +: DATA_W];
      if (fwd_sel_b == SEL_W'(k)) op_b = fwd_data[(k-1)*DATA_W +: DATA_W];
    end
  end

  // In both placements the sign bit of the 16-bit base is imm8[7].
  logic [15:0]       base16, sx16;
  logic [DATA_W-1:0] imm_ext;
  always_comb begin
    base16  = ext_high ? {imm8, 8'h00} : {8'h00, imm8};
    sx16    = ext_high ? base16 : {{8{imm8[7]}}, imm8};
    imm_ext = '0;
    imm_ext[15:0] = ext_signed ? sx16 : base16;
    for (int i = 16; i < DATA_W; i++) imm_ext[i] = ext_signed & imm8[7];
  end

  logic cmp_gt, cmp_lt, cmp_eq;
  assign cmp_gt = $signed(op_a) > $signed(op_b);
  assign cmp_lt = $signed(op_a) < $signed(op_b);
  assign cmp_eq = op_a == op_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      rd_out    <= '0;
      imm_out   <= '0;
      pc_out    <= '0;
      i_target  <= '0;
      j_target  <= '0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      rd_out    <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      a         <= op_a;
      b         <= op_b;
      rd_out    <= rd_next;
      imm_out   <= imm_ext;
      pc_out    <= npc;
      i_target  <= npc + imm_ext;
      j_target  <= {npc[DATA_W-1:12], jimm};
      gt        <= cmp_gt;
      lt        <= cmp_lt;
      eq        <= cmp_eq;
    end
  end

endmodule
